liteic_master_node_read_ot: RTL and testbench



---
 rtl/liteic_master_node_read_ot.sv | 142 ++++++++++++++
 tb/tb_liteic_master_node_read_ot.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/liteic_master_node_read_ot.sv
// AXI-Lite read node: decodes AR into per-slot crossbar requests, keeps up to MAX_OT reads
// in flight and returns R beats in issue order. Define LITEIC_RD_OT_STATS_EN for counters.
module liteic_master_node_read_ot #(
  parameter int                        NUM_SLV      = 12,
  parameter int                        ADDR_W       = 32,
  parameter int                        DATA_W       = 32,
  parameter int                        MAX_OT       = 4,
  parameter logic [NUM_SLV-1:0]        CONNECTIVITY = '1,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE     = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_SIZE     = '0
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            ar_valid_i,
  input  logic [ADDR_W-1:0]               ar_addr_i,
  output logic                            ar_ready_o,
  output logic                            r_valid_o,
  output logic [DATA_W-1:0]               r_data_o,
  output logic [1:0]                      r_resp_o,
  input  logic                            r_ready_i,
  output logic [NUM_SLV-1:0]              cbar_reqst_val_o,
  input  logic [NUM_SLV-1:0]              cbar_reqst_rdy_i,
  output logic [ADDR_W-1:0]               cbar_reqst_data_o,
  input  logic [NUM_SLV-1:0]              cbar_resp_val_i,
  input  logic [NUM_SLV*(DATA_W+2)-1:0]   cbar_resp_data_i,
  output logic [NUM_SLV-1:0]              cbar_resp_rdy_o
`ifdef LITEIC_RD_OT_STATS_EN
  ,
  output logic [$clog2(MAX_OT+1)-1:0]     ot_cnt_o,
  output logic [15:0]                     decerr_cnt_o,
  output logic [15:0]                     stall_cnt_o
`endif
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int PTR_W = (MAX_OT > 1) ? $clog2(MAX_OT) : 1;
  localparam int CNT_W = $clog2(MAX_OT + 1);
  localparam int RSP_W = DATA_W + 2;

  logic [NUM_SLV-1:0] w_hit;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_illegal;
  logic               w_full, w_empty, w_ar_ready, w_push, w_pop;
  logic               w_head_err;
  logic [IDX_W-1:0]   w_head_idx;
  logic [RSP_W-1:0]   w_head_word;

  logic               r_err_mem [MAX_OT];
  logic [IDX_W-1:0]   r_idx_mem [MAX_OT];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;

  // Region compare is widened by one bit so base+size never wraps at the top of the map.
  for (genvar g = 0; g < NUM_SLV; g++) begin : g_dec
    logic [ADDR_W:0] w_base, w_lim;
    assign w_base   = {1'b0, SLV_BASE[g*ADDR_W +: ADDR_W]};
    assign w_lim    = w_base + {1'b0, SLV_SIZE[g*ADDR_W +: ADDR_W]};
    assign w_hit[g] = CONNECTIVITY[g] && (SLV_SIZE[g*ADDR_W +: ADDR_W] != '0) &&
                      ({1'b0, ar_addr_i} >= w_base) && ({1'b0, ar_addr_i} < w_lim);
  end

  always_comb begin
    w_illegal = 1'b1;
    w_sel_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_illegal = 1'b0;
        w_sel_idx = IDX_W'(i);
      end
    end
  end

  // Handshakes are plain valid/ready: a transfer happens on a clock edge where both are high;
  // ready never waits on valid, and a pop in the same cycle does not make room for a push.
  assign w_full     = (r_cnt == CNT_W'(MAX_OT));
  assign w_empty    = (r_cnt == '0);
  assign w_ar_ready = !w_full && (w_illegal || cbar_reqst_rdy_i[w_sel_idx]);
  assign w_push     = ar_valid_i && w_ar_ready;

  assign ar_ready_o        = w_ar_ready;
  assign cbar_reqst_data_o = ar_addr_i;
  assign cbar_reqst_val_o  = (ar_valid_i && !w_full && !w_illegal) ?
                             (NUM_SLV'(1) << w_sel_idx) : '0;

  assign w_head_err  = r_err_mem[r_rd_ptr];
  assign w_head_idx  = r_idx_mem[r_rd_ptr];
  assign w_head_word = cbar_resp_data_i[w_head_idx*RSP_W +: RSP_W];

  // Only the head slot is ever offered rready, which keeps R strictly in issue order.
  assign r_valid_o       = !w_empty && (w_head_err || cbar_resp_val_i[w_head_idx]);
  assign r_data_o        = w_head_err ? '0 : w_head_word[RSP_W-1:2];
  assign r_resp_o        = w_head_err ? 2'b11 : w_head_word[1:0];
  assign cbar_resp_rdy_o = (!w_empty && !w_head_err && r_ready_i) ?
                           (NUM_SLV'(1) << w_head_idx) : '0;
  assign w_pop           = r_valid_o && r_ready_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OT - 1)) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_err_mem[r_wr_ptr] <= w_illegal;
      r_idx_mem[r_wr_ptr] <= w_sel_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef LITEIC_RD_OT_STATS_EN
  logic [15:0] r_decerr_cnt, r_stall_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_decerr_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_pop && w_head_err && (r_decerr_cnt != 16'hFFFF)) r_decerr_cnt <= r_decerr_cnt + 16'd1;
      if (ar_valid_i && w_full && (r_stall_cnt != 16'hFFFF))  r_stall_cnt  <= r_stall_cnt + 16'd1;
    end
  end

  assign ot_cnt_o     = r_cnt;
  assign decerr_cnt_o = r_decerr_cnt;
  assign stall_cnt_o  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_liteic_master_node_read_ot.sv
// Bench for liteic_master_node_read_ot: random slaves plus directed scenarios, all outputs
// compared every cycle against a queue-based model of the issue-order read node.
module tb_liteic_master_node_read_ot;
  localparam int NS = 12;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OT = 4;
  localparam int RW = DW + 2;
  localparam int EW = 1 + 4 + RW;

  // slot 11 overlaps 0..0x1FFFF, slot 10 sits at the top of the map, slot 7 unmapped, slot 9 cut
  localparam logic [NS-1:0] P_CONN = 12'hDFF;
  localparam logic [NS*AW-1:0] P_BASE = {
    32'h0000_0000, 32'hFFFF_F000, 32'h0000_9000, 32'h0000_8000, 32'h0000_7000, 32'h0000_6000,
    32'h0000_5000, 32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] P_SIZE = {
    32'h0002_0000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_0000, 32'h0000_1000,
    32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000};

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              ar_valid_i = 1'b0;
  logic [AW-1:0]     ar_addr_i = '0;
  logic              ar_ready_o;
  logic              r_valid_o;
  logic [DW-1:0]     r_data_o;
  logic [1:0]        r_resp_o;
  logic              r_ready_i = 1'b1;
  logic [NS-1:0]     cbar_reqst_val_o;
  logic [NS-1:0]     cbar_reqst_rdy_i = '1;
  logic [AW-1:0]     cbar_reqst_data_o;
  logic [NS-1:0]     cbar_resp_val_i = '0;
  logic [NS*RW-1:0]  cbar_resp_data_i = '0;
  logic [NS-1:0]     cbar_resp_rdy_o;
`ifdef LITEIC_RD_OT_STATS_EN
  logic [2:0]        ot_cnt_o;
  logic [15:0]       decerr_cnt_o, stall_cnt_o;
`endif

  liteic_master_node_read_ot #(
    .NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .MAX_OT(OT),
    .CONNECTIVITY(P_CONN), .SLV_BASE(P_BASE), .SLV_SIZE(P_SIZE)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ar_valid_i(ar_valid_i), .ar_addr_i(ar_addr_i), .ar_ready_o(ar_ready_o),
    .r_valid_o(r_valid_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_ready_i(r_ready_i),
    .cbar_reqst_val_o(cbar_reqst_val_o), .cbar_reqst_rdy_i(cbar_reqst_rdy_i),
    .cbar_reqst_data_o(cbar_reqst_data_o), .cbar_resp_val_i(cbar_resp_val_i),
    .cbar_resp_data_i(cbar_resp_data_i), .cbar_resp_rdy_o(cbar_resp_rdy_o)
`ifdef LITEIC_RD_OT_STATS_EN
    , .ot_cnt_o(ot_cnt_o), .decerr_cnt_o(decerr_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // environment knobs (main process writes, env loop reads)
  logic [NS-1:0] hold = '0;
  bit            rdy_mode = 1'b1;
  int            rr_mode = 2;
  int            pres_p = 3;

  // scoreboard: {err, slot[3:0], {data,resp}} in issue order
  logic [EW-1:0]   exp_q[$];
  logic [4+RW-1:0] pend_q[$];
  logic [RW-1:0]   r_hist[$];
  logic [NS-1:0]   s_val = '0;
  logic [RW-1:0]   s_beat [NS];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event t=%0t", nm, $time);
  endtask

  function automatic logic [RW-1:0] slave_beat(input logic [AW-1:0] a);
    return {16'hCAFE, a[15:0] ^ 16'h2005, a[4], 1'b0};
  endfunction

  function automatic int ref_slot(input logic [AW-1:0] a);
    longint base, size;
    for (int i = 0; i < NS; i++) begin
      base = longint'(P_BASE[i*AW +: AW]);
      size = longint'(P_SIZE[i*AW +: AW]);
      if (P_CONN[i] && size != 0 && longint'(a) >= base && longint'(a) < base + size) return i;
    end
    return -1;
  endfunction

  function automatic logic [EW-1:0] exp_entry(input logic [AW-1:0] a);
    int s;
    s = ref_slot(a);
    if (s < 0) return {1'b1, 4'd0, {32'd0, 2'b11}};
    return {1'b0, 4'(s), slave_beat(a)};
  endfunction

  // per-cycle compare against the model, then slave/model bookkeeping
  task automatic mon_step();
    int s, hs;
    logic e_arr, e_rv;
    logic [NS-1:0] e_val, e_rrdy;
    logic [EW-1:0] h;
    s = ref_slot(ar_addr_i);
    e_arr = (exp_q.size() < OT) && ((s < 0) || cbar_reqst_rdy_i[s]);
    e_val = '0;
    if (ar_valid_i && exp_q.size() < OT && s >= 0) e_val = NS'(1) << s;
    e_rv = 1'b0; e_rrdy = '0; h = '0;
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      hs = int'(h[EW-2:RW]);
      if (h[EW-1]) e_rv = 1'b1;
      else begin
        e_rv = cbar_resp_val_i[hs];
        if (r_ready_i) e_rrdy = NS'(1) << hs;
      end
    end
    chk("ar_ready", ar_ready_o, e_arr);
    chk("reqst_val", cbar_reqst_val_o, e_val);
    chk("reqst_data", cbar_reqst_data_o, ar_addr_i);
    chk("r_valid", r_valid_o, e_rv);
    chk("resp_rdy", cbar_resp_rdy_o, e_rrdy);
    if (e_rv) chk("r_beat", {r_data_o, r_resp_o}, h[RW-1:0]);
`ifdef LITEIC_RD_OT_STATS_EN
    chk("ot_cnt", ot_cnt_o, exp_q.size());
`endif
    if (r_valid_o && r_ready_i) r_hist.push_back({r_data_o, r_resp_o});
    for (int i = 0; i < NS; i++) begin
      if (cbar_reqst_val_o[i] && cbar_reqst_rdy_i[i])
        pend_q.push_back({4'(i), slave_beat(cbar_reqst_data_o)});
      if (cbar_resp_val_i[i] && cbar_resp_rdy_o[i]) s_val[i] = 1'b0;
    end
    if (e_rv && r_ready_i) void'(exp_q.pop_front());
    if (ar_valid_i && e_arr) exp_q.push_back(exp_entry(ar_addr_i));
  endtask

  task automatic env_drive();
    cbar_reqst_rdy_i = rdy_mode ? '1 : NS'($urandom);
    r_ready_i = (rr_mode == 0) ? 1'($urandom_range(0, 1)) : (rr_mode == 2);
    for (int i = 0; i < NS; i++) begin
      if (!s_val[i] && !hold[i] && $urandom_range(0, 7) < pres_p) begin
        for (int k = 0; k < pend_q.size(); k++) begin
          if (int'(pend_q[k][RW+3:RW]) == i) begin
            s_val[i]  = 1'b1;
            s_beat[i] = pend_q[k][RW-1:0];
            pend_q.delete(k);
            break;
          end
        end
      end
      cbar_resp_val_i[i] = s_val[i];
      cbar_resp_data_i[i*RW +: RW] = s_beat[i];
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) s_beat[i] = '0;
    forever begin
      @(negedge clk_i);
      if (rstn_i) mon_step();
      else begin
        exp_q.delete();
        pend_q.delete();
        s_val = '0;
      end
      @(posedge clk_i);
      #1;
      env_drive();
    end
  end

  // driver tasks
  task automatic do_ar(input logic [AW-1:0] a, input bit do_chk, input logic [NS-1:0] exp_v);
    bit done;
    done = 1'b0;
    @(posedge clk_i); #2;
    ar_valid_i = 1'b1;
    ar_addr_i  = a;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk_i);
      if (do_chk && k == 0) chk("dec_onehot", cbar_reqst_val_o, exp_v);
      if (ar_ready_o) done = 1'b1;
    end
    if (!done) fail_timeout("ar_handshake");
    @(posedge clk_i); #2;
    ar_valid_i = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int k;
    for (k = 0; k < 1000 && r_hist.size() < target; k++) @(posedge clk_i);
    if (r_hist.size() < target) fail_timeout("r_beats");
  endtask

  task automatic wait_empty();
    int k;
    for (k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk_i);
    if (exp_q.size() != 0) fail_timeout("drain");
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_0000;
      1:       return 32'h0002_0000 + 32'($urandom_range(0, 1023)) * 4;
      2:       return 32'hFFFF_F000 + 32'($urandom_range(0, 1023)) * 4;
      3:       return 32'h0001_FFFC;
      4:       return 32'h0000_C000 + 32'($urandom_range(0, 4095)) * 4;
      default: return 32'($urandom_range(0, 9)) * 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
    endcase
  endfunction

  initial begin
    int n0;
    bit seen;
    logic [RW-1:0] held;

    // reset state
    ar_addr_i = 32'h0000_2004;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_r_valid", r_valid_o, 1'b0);
    chk("rst_reqst_val", cbar_reqst_val_o, 12'h000);
    chk("rst_resp_rdy", cbar_resp_rdy_o, 12'h000);
    chk("rst_ar_ready", ar_ready_o, 1'b1);
    @(posedge clk_i); #3;
    rstn_i = 1'b1;

    // single read to slot 2
    do_ar(32'h0000_2004, 1'b1, 12'h004);
    wait_beats(1);
    chk("single_beat", r_hist[0], {32'hCAFE_0001, 2'b00});

    // decode corners: overlap, unmapped, disconnected, top-of-map, region edges
    do_ar(32'h0000_0010, 1'b1, 12'h001); wait_empty();
    do_ar(32'h0000_7010, 1'b1, 12'h800); wait_empty();
    do_ar(32'h0000_9000, 1'b1, 12'h800); wait_empty();
    do_ar(32'hFFFF_FFFC, 1'b1, 12'h400); wait_empty();
    do_ar(32'h0001_FFFC, 1'b1, 12'h800); wait_empty();
    do_ar(32'h0002_0000, 1'b1, 12'h000); wait_empty();

    // DECERR between two legal reads
    rr_mode = 1;
    n0 = r_hist.size();
    do_ar(32'h0000_3000, 1'b1, 12'h008);
    do_ar(32'hFFFF_0000, 1'b1, 12'h000);
    do_ar(32'h0000_4000, 1'b1, 12'h010);
    rr_mode = 2;
    wait_beats(n0 + 3);
    chk("decerr_first", r_hist[n0], slave_beat(32'h0000_3000));
    chk("decerr_second", r_hist[n0+1], {32'h0, 2'b11});
    chk("decerr_third", r_hist[n0+2], slave_beat(32'h0000_4000));

    // out-of-order slaves: slot 1 answers while slot 5 is held
    hold = 12'h020;
    n0 = r_hist.size();
    do_ar(32'h0000_5000, 1'b1, 12'h020);
    do_ar(32'h0000_1000, 1'b1, 12'h002);
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    chk("ooo_slot1_rdy", cbar_resp_rdy_o[1], 1'b0);
    chk("ooo_rdy_head", cbar_resp_rdy_o, 12'h020);
    hold = '0;
    wait_beats(n0 + 2);
    chk("ooo_first", r_hist[n0], slave_beat(32'h0000_5000));
    chk("ooo_second", r_hist[n0+1], slave_beat(32'h0000_1000));

    // full: four reads to a silent slot, fifth stalls until the cycle after a pop
    hold = 12'h008;
    for (int i = 0; i < 4; i++) do_ar(32'h0000_3000 + 32'(i) * 4, 1'b1, 12'h008);
    @(posedge clk_i); #2;
    ar_valid_i = 1'b1;
    ar_addr_i  = 32'h0000_3010;
    @(negedge clk_i);
    chk("full_ar_ready", ar_ready_o, 1'b0);
    chk("full_reqst_val", cbar_reqst_val_o, 12'h000);
    repeat (3) @(posedge clk_i);
    hold = '0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk_i);
      if (r_valid_o && r_ready_i) seen = 1'b1;
    end
    if (!seen) fail_timeout("full_pop");
    chk("full_pop_same_cycle", ar_ready_o, 1'b0);
    @(negedge clk_i);
    chk("full_next_cycle", ar_ready_o, 1'b1);
    chk("full_next_val", cbar_reqst_val_o, 12'h008);
    @(posedge clk_i); #2;
    ar_valid_i = 1'b0;
    wait_empty();

    // backpressure: head valid held for 10 cycles, one ready pulse pops one entry
    rr_mode = 1;
    do_ar(32'h0000_5008, 1'b1, 12'h020);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk_i);
      if (r_valid_o) seen = 1'b1;
    end
    if (!seen) fail_timeout("bp_valid");
    held = slave_beat(32'h0000_5008);
    n0 = r_hist.size();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      chk("bp_valid_hold", r_valid_o, 1'b1);
      chk("bp_data_hold", {r_data_o, r_resp_o}, held);
    end
    @(posedge clk_i); #2; rr_mode = 2;
    @(posedge clk_i); #2; rr_mode = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("bp_one_pop", r_hist.size(), n0 + 1);
    chk("bp_empty_after", r_valid_o, 1'b0);

    // randomized traffic
    rdy_mode = 1'b0;
    rr_mode  = 0;
    for (int n = 0; n < 240; n++) begin
      if (n % 40 == 0) pres_p = $urandom_range(1, 7);
      do_ar(rand_addr(), 1'b0, '0);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end
    wait_empty();

    // reset with three outstanding, DECERR at the head
    rdy_mode = 1'b1;
    rr_mode  = 1;
    pres_p   = 3;
    do_ar(32'hFFFF_0000, 1'b0, '0);
    do_ar(32'h0000_2000, 1'b0, '0);
    do_ar(32'h0000_6000, 1'b0, '0);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_valid", r_valid_o, 1'b1);
    @(posedge clk_i); #4;
    rstn_i = 1'b0;
    #1;
    chk("async_rst_valid", r_valid_o, 1'b0);
    chk("async_rst_rdy", cbar_resp_rdy_o, 12'h000);
`ifdef LITEIC_RD_OT_STATS_EN
    chk("async_rst_ot", ot_cnt_o, 3'd0);
    chk("async_rst_decerr", decerr_cnt_o, 16'd0);
`endif
    repeat (2) @(posedge clk_i);
    #3;
    rstn_i  = 1'b1;
    rr_mode = 2;
    n0 = r_hist.size();
    do_ar(32'h0000_2004, 1'b1, 12'h004);
    wait_beats(n0 + 1);
    chk("post_rst_beat", r_hist[n0], {32'hCAFE_0001, 2'b00});
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
